tdm_mux_8to1: RTL and testbench
===============================

Name: tdm_mux_8to1

Overview:
- Time-division multiplexer that collects 8 parallel channels onto one serial lane, one slot per enabled cycle.
- Drives a 3-bit slot select alongside each datum so a downstream demux_1to8 can route it back out (data_out -> data_in, sel_out -> select).
- All 8 channels are snapshotted together at each frame boundary, so every frame is coherent.
- Includes a frame counter and a frame-sync pulse for link monitoring.

Parameters:
- DATA_W, 1, width of each channel and of data_out.
- FCNT_W, 8, width of the frame counter (wraps modulo 2^FCNT_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high; clears all state immediately.
- en  input  1  run/pause; sampled each rising edge.
- ch_in  input  8*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- data_out  output  DATA_W  current slot datum, registered.
- sel_out  output  3  slot index of data_out, registered.
- out_valid  output  1  data_out/sel_out carry a new slot this cycle.
- frame_sync  output  1  high together with out_valid when sel_out==0.
- busy  output  1  high while in RUN, including paused cycles.
- frame_cnt  output  FCNT_W  number of completed frames (slot 7 emitted).

Behaviour:
- Reset values: all outputs 0, state IDLE, slot counter 0, shadow register 0.
- State IDLE:
  - out_valid=0, frame_sync=0.
  - data_out and sel_out hold their last values (0 after reset).
  - en=1 at an edge: capture ch_in into shadow, slot<=0, go to RUN.
  - No slot is emitted on that edge.
- State RUN with en=1 at an edge:
  - data_out<=shadow[slot], sel_out<=slot, out_valid<=1.
  - frame_sync<=(slot==0).
  - slot<=slot+1.
- Wrap at slot==7 (RUN, en=1):
  - Emit slot 7 from the old shadow.
  - On the same edge, recapture ch_in into shadow, set slot<=0, increment frame_cnt.
  - Back-to-back frames have no gap: 8 valid cycles per frame.
- State RUN with en=0 at an edge (pause):
  - out_valid<=0, frame_sync<=0; slot and shadow hold.
  - Stay in RUN; the next en=1 edge resumes at the held slot using the same shadow.
- Leaving RUN:
  - Only rst returns the block to IDLE. After reset, the next en=1 edge re-enters RUN with a fresh capture.
- Latency:
  - First en=1 edge captures.
  - Slot 0 appears after the next en=1 edge (1 cycle after capture).
  - Slot k appears k+1 enabled edges after capture.
- Coherency: ch_in changes during a frame are invisible until the next capture.
- frame_cnt: increments only on a slot-7 emit and wraps from 2^FCNT_W-1 to 0.
- Async reset mid-frame: outputs drop to 0 immediately and the partial frame is discarded (no frame_cnt increment).
- busy is 1 in RUN and 0 in IDLE.

Decomposition:
- Shared package tdm_pkg holds:
  - NUM_CH=8 and SEL_W=3 constants.
  - State encoding IDLE=1'b0, RUN=1'b1.
  - These constants are shared with the demux-side receiver.
- One natural sub-module, tdm_slot_counter:
  - 3-bit slot counter with enable, wrap flag and synchronous load-to-0.
  - Async reset on rst.
- The frame counter and shadow register stay in the top module.

Test Plan:
- Reset with en=0, ch_in=8'hA5 (DATA_W=1):
  - All outputs 0, busy=0, no out_valid for 10 cycles.
- en=1 continuously, ch_in=8'b1011_0010:
  - After the capture edge, 8 valid cycles with sel_out 0..7 and data_out 0,1,0,0,1,1,0,1.
  - frame_sync only on sel 0; frame_cnt becomes 1 after sel 7.
- Run 3 frames, changing ch_in to 8'hFF during frame 1:
  - Frame 1 emits the old snapshot.
  - Frames 2 and 3 emit all 1s with no gap cycle.
  - frame_cnt=3.
- Pause: drop en for 4 cycles after sel_out=3 is emitted:
  - out_valid=0 for 4 cycles, busy=1.
  - On resume, the next emit is sel_out=4 from the same snapshot.
- Assert rst asynchronously (mid-cycle) while sel_out=5:
  - All outputs read 0 before the next clock edge.
  - Restart with en=1 gives a fresh capture and emission from sel 0; frame_cnt=0.
- Close the loop with FCNT_W=2 through demux_1to8:
  - Feed data_out/sel_out into demux_1to8.
  - Each demux output k shows ch_in bit k during its slot.
  - frame_cnt wraps 3->0 after the 4th frame.

Source files
------------

// File: rtl/tdm_pkg.sv
// Constants and state encoding shared by the TDM mux and the demux-side receiver.
package tdm_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: counts enabled slots, flags the last slot, loads to zero on request.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             load_i,
  output logic [SEL_W-1:0] slot_o,
  output logic             wrap_o
);

  logic [SEL_W-1:0] slot_d, slot_q;

  always_comb begin
    slot_d = slot_q;
    if (load_i) begin
      slot_d = '0;
    end else if (inc_i) begin
      slot_d = slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  // Natural 3-bit rollover already returns the counter to 0 after the last slot.
  assign wrap_o = inc_i && (slot_q == SEL_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_mux_8to1.sv
// 8-to-1 time-division multiplexer with per-frame coherent snapshot and frame counter.
module tdm_mux_8to1
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int FCNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH*DATA_W-1:0] ch_in,
  output logic [DATA_W-1:0]        data_out,
  output logic [SEL_W-1:0]         sel_out,
  output logic                     out_valid,
  output logic                     frame_sync,
  output logic                     busy,
  output logic [FCNT_W-1:0]        frame_cnt
);

  tdm_state_e               state_q;
  logic [NUM_CH*DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0]        data_q;
  logic [SEL_W-1:0]         sel_q;
  logic                     valid_q;
  logic                     sync_q;
  logic [FCNT_W-1:0]        fcnt_q;

  logic [SEL_W-1:0] slot;
  logic             slot_wrap;
  logic             emit;
  logic             start;

  assign emit  = (state_q == StRun) && en;
  assign start = (state_q == StIdle) && en;

  tdm_slot_counter u_slot_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (emit),
    .load_i (start),
    .slot_o (slot),
    .wrap_o (slot_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          sync_q  <= 1'b0;
          if (en) begin
            shadow_q <= ch_in;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (en) begin
            data_q  <= shadow_q[int'(slot)*DATA_W +: DATA_W];
            sel_q   <= slot;
            valid_q <= 1'b1;
            sync_q  <= (slot == '0);
            // Last slot still reads the old snapshot; the new frame is captured on this same edge.
            if (slot_wrap) begin
              shadow_q <= ch_in;
              fcnt_q   <= fcnt_q + FCNT_W'(1);
            end
          end else begin
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign sel_out    = sel_q;
  assign out_valid  = valid_q;
  assign frame_sync = sync_q;
  assign busy       = (state_q == StRun);
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Self-checking bench for tdm_mux_8to1: vector table, directed corner sequences, random run.
module tb_tdm_mux_8to1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] ch;

  logic       data_a, valid_a, sync_a, busy_a;
  logic [2:0] sel_a;
  logic [7:0] cnt_a;
  logic       data_b, valid_b, sync_b, busy_b;
  logic [2:0] sel_b;
  logic [1:0] cnt_b;

  tdm_mux_8to1 #(.DATA_W(1), .FCNT_W(8)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_in      (ch),
    .data_out   (data_a),
    .sel_out    (sel_a),
    .out_valid  (valid_a),
    .frame_sync (sync_a),
    .busy       (busy_a),
    .frame_cnt  (cnt_a)
  );

  tdm_mux_8to1 #(.DATA_W(1), .FCNT_W(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_in      (ch),
    .data_out   (data_b),
    .sel_out    (sel_b),
    .out_valid  (valid_b),
    .frame_sync (sync_b),
    .busy       (busy_b),
    .frame_cnt  (cnt_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference: a snapshot array, an integer slot position and a frame tally.
  bit       m_run;
  bit       m_snap [8];
  int       m_pos;
  int       m_frames;
  logic     m_valid, m_sync, m_data;
  int       m_sel;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_frames = 0;
    m_valid = 0; m_sync = 0; m_data = 0; m_sel = 0;
    for (int k = 0; k < 8; k++) m_snap[k] = 0;
  endtask

  task automatic model_capture(input logic [7:0] c);
    for (int k = 0; k < 8; k++) m_snap[k] = c[k];
    m_pos = 0;
  endtask

  task automatic model_edge(input logic e, input logic [7:0] c);
    if (!m_run) begin
      m_valid = 0; m_sync = 0;
      if (e) begin
        m_run = 1;
        model_capture(c);
      end
    end else if (e) begin
      m_data  = m_snap[m_pos];
      m_sel   = m_pos;
      m_valid = 1;
      m_sync  = (m_pos == 0);
      if (m_pos == 7) begin
        m_frames++;
        model_capture(c);
      end else begin
        m_pos++;
      end
    end else begin
      m_valid = 0; m_sync = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/valid"}, 32'(valid_a), 32'(m_valid));
    chk({tag, "/sync"},  32'(sync_a),  32'(m_sync));
    chk({tag, "/busy"},  32'(busy_a),  32'(m_run));
    chk({tag, "/data"},  32'(data_a),  32'(m_data));
    chk({tag, "/sel"},   32'(sel_a),   32'(m_sel));
    chk({tag, "/cnt"},   32'(cnt_a),   32'(m_frames % 256));
    chk({tag, "/cnt2"},  32'(cnt_b),   32'(m_frames % 4));
  endtask

  task automatic step(input logic e, input logic [7:0] c);
    @(negedge clk);
    en = e;
    ch = c;
    @(posedge clk);
    model_edge(e, c);
    #1;
    check_model("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] ch;
    logic       valid;
    logic [2:0] sel;
    logic       data;
    logic       sync;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [7:0] cap [5];
    logic [7:0] demux;
    logic [7:0] nxt;
    int         valid_run;
    int         ones;

    rst = 1'b1;
    en  = 1'b0;
    ch  = 8'hA5;
    model_reset();

    // Capture edge, then one frame of 8'b1011_0010 emitted LSB channel first.
    tbl[0] = '{1'b1, 8'hB2, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 8'hB2, 1'b1, 3'd0, 1'b0, 1'b1, 8'd0};
    tbl[2] = '{1'b1, 8'hB2, 1'b1, 3'd1, 1'b1, 1'b0, 8'd0};
    tbl[3] = '{1'b1, 8'hB2, 1'b1, 3'd2, 1'b0, 1'b0, 8'd0};
    tbl[4] = '{1'b1, 8'hB2, 1'b1, 3'd3, 1'b0, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 8'hB2, 1'b1, 3'd4, 1'b1, 1'b0, 8'd0};
    tbl[6] = '{1'b1, 8'hB2, 1'b1, 3'd5, 1'b1, 1'b0, 8'd0};
    tbl[7] = '{1'b1, 8'hB2, 1'b1, 3'd6, 1'b0, 1'b0, 8'd0};
    tbl[8] = '{1'b1, 8'hB2, 1'b1, 3'd7, 1'b1, 1'b0, 8'd1};

    #12;
    check_model("por");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'hA5);
      chk("idle/valid", 32'(valid_a), 32'd0);
      chk("idle/busy",  32'(busy_a),  32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].en, tbl[i].ch);
      chk($sformatf("tbl%0d/valid", i), 32'(valid_a), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d/sel", i),   32'(sel_a),   32'(tbl[i].sel));
      chk($sformatf("tbl%0d/data", i),  32'(data_a),  32'(tbl[i].data));
      chk($sformatf("tbl%0d/sync", i),  32'(sync_a),  32'(tbl[i].sync));
      chk($sformatf("tbl%0d/cnt", i),   32'(cnt_a),   32'(tbl[i].cnt));
    end

    // Three back-to-back frames; inputs change to all-ones mid frame 1.
    do_reset();
    step(1'b1, 8'hB2);
    valid_run = 0;
    ones      = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, (i >= 3) ? 8'hFF : 8'hB2);
      if (valid_a) valid_run++;
      if (i >= 8 && data_a) ones++;
      if (i < 8) chk("coh/frame1", 32'(data_a), 32'((8'hB2 >> i) & 8'h1));
    end
    chk("frames3/valid_run", 32'(valid_run), 32'd24);
    chk("frames3/ones",      32'(ones),      32'd16);
    chk("frames3/cnt",       32'(cnt_a),     32'd3);

    // Pause after slot 3 is emitted; resume must continue at slot 4 of the same snapshot.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h5A);
    chk("pause/pre_sel", 32'(sel_a), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00);
      chk("pause/valid", 32'(valid_a), 32'd0);
      chk("pause/busy",  32'(busy_a),  32'd1);
    end
    step(1'b1, 8'h00);
    chk("resume/sel",   32'(sel_a),   32'd4);
    chk("resume/valid", 32'(valid_a), 32'd1);
    chk("resume/data",  32'(data_a),  32'd1);

    // Asynchronous reset mid-cycle while slot 5 is on the output.
    step(1'b1, 8'h00);
    chk("arst/pre_sel", 32'(sel_a), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst/data",  32'(data_a),  32'd0);
    chk("arst/sel",   32'(sel_a),   32'd0);
    chk("arst/valid", 32'(valid_a), 32'd0);
    chk("arst/busy",  32'(busy_a),  32'd0);
    chk("arst/cnt",   32'(cnt_a),   32'd0);
    model_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    step(1'b1, 8'h81);
    step(1'b1, 8'h81);
    chk("restart/sel",  32'(sel_a),  32'd0);
    chk("restart/sync", 32'(sync_a), 32'd1);
    chk("restart/data", 32'(data_a), 32'd1);
    chk("restart/cnt",  32'(cnt_a),  32'd0);

    // Loop through a demux model: each routed channel must equal its captured input bit.
    do_reset();
    cap[0] = 8'($urandom);
    step(1'b1, cap[0]);
    for (int f = 0; f < 4; f++) begin
      demux  = 8'h00;
      nxt    = 8'($urandom);
      cap[f+1] = nxt;
      for (int k = 0; k < 8; k++) begin
        step(1'b1, (k == 7) ? nxt : cap[f]);
        if (valid_b) demux[sel_b] = data_b;
      end
      chk($sformatf("demux/frame%0d", f), 32'(demux), 32'(cap[f]));
      chk($sformatf("wrap/cnt2_f%0d", f), 32'(cnt_b), 32'((f + 1) % 4));
    end

    // Random run with pauses against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
